// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: bundles the serial line, baud select and receive results
// of the 8N1 UART receiver.
//   uart_rx   : serial input, idle high (driven by master)
//   Buad_set  : baud select, same encoding as the byte transmitter
//   data_byte : last correctly received byte
//   Rx_done   : one-cycle strobe when data_byte updates
//   frame_err : one-cycle strobe when the stop bit reads low
//   rx_busy   : high while a frame is being received
interface uart_rx_byte_if;
    logic       uart_rx;
    logic [2:0] Buad_set;
    logic [7:0] data_byte;
    logic       Rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output uart_rx,
        output Buad_set,
        input  data_byte,
        input  Rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  uart_rx,
        input  Buad_set,
        output data_byte,
        output Rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, 16x oversampled with a
// three-sample majority vote per bit.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   rx_if  : slave side of uart_rx_byte_if (serial in, baud select,
//            received byte, done / framing-error strobes, busy)
// Baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_byte_if.slave rx_if
);

    localparam logic [8:0] DIV_9600   = 9'(CLK_FREQ / (9600   * OVERSAMPLE));
    localparam logic [8:0] DIV_19200  = 9'(CLK_FREQ / (19200  * OVERSAMPLE));
    localparam logic [8:0] DIV_38400  = 9'(CLK_FREQ / (38400  * OVERSAMPLE));
    localparam logic [8:0] DIV_57600  = 9'(CLK_FREQ / (57600  * OVERSAMPLE));
    localparam logic [8:0] DIV_115200 = 9'(CLK_FREQ / (115200 * OVERSAMPLE));

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t     state_q;
    logic       sync1_q, sync2_q, prev_q;
    logic [8:0] div_q;
    logic [8:0] div_d;
    logic [8:0] div_cnt_q;
    logic [3:0] samp_q;
    logic [2:0] bit_idx_q;
    logic       s7_q, s8_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       done_q, ferr_q, busy_q;

    logic       start_det;
    logic       phase_run;
    logic       tick;
    logic       vote;

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    // Reset to the idle level so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        div_d = DIV_9600;
        case (rx_if.Buad_set)
            3'd1:    div_d = DIV_19200;
            3'd2:    div_d = DIV_38400;
            3'd3:    div_d = DIV_57600;
            3'd4:    div_d = DIV_115200;
            default: div_d = DIV_9600;
        endcase
    end

    always_comb begin
        start_det = (state_q == S_IDLE) && prev_q && !sync2_q;
        phase_run = state_q inside {S_START, S_DATA, S_STOP};
        tick      = phase_run && (div_cnt_q == div_q - 9'd1);
        // Third sample is the live synchronized line at tick 9.
        vote      = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= DIV_9600;
            div_cnt_q <= '0;
            samp_q    <= '0;
            bit_idx_q <= '0;
            s7_q      <= 1'b1;
            s8_q      <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;

            // Divider only runs inside a frame; it restarts from 0 on the
            // start edge because IDLE holds it there.
            if (!phase_run || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + 9'd1;
            end

            if (tick) begin
                samp_q <= samp_q + 4'd1;
                if (samp_q == 4'd7) s7_q <= sync2_q;
                if (samp_q == 4'd8) s8_q <= sync2_q;
            end

            case (state_q)
                S_IDLE: begin
                    samp_q    <= '0;
                    bit_idx_q <= '0;
                    if (start_det) begin
                        state_q <= S_START;
                        div_q   <= div_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick && samp_q == 4'd9 && vote) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick && samp_q == 4'd15) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (tick && samp_q == 4'd9) begin
                        shift_q[bit_idx_q] <= vote;
                    end
                    if (tick && samp_q == 4'd15) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Decided mid stop bit so a back-to-back start edge is
                    // seen right after a single stop bit.
                    if (tick && samp_q == 4'd9) begin
                        if (vote) begin
                            data_q  <= shift_q;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_byte = data_q;
    assign rx_if.Rx_done   = done_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scenario tasks drive serial frames into uart_rx_byte; a
// negedge monitor collects delivered bytes and strobe statistics, and each
// task compares them against bytes it queued when driving the frame.
// The clock is 7.3728 MHz so every baud divisor is exact (48/24/12/8/4)
// and bit periods are 768/384/192/128/64 clocks, keeping 9600-baud frames
// short enough for simulation.
module tb_uart_rx_byte;

    localparam int unsigned CLK_HZ = 7372800;

    logic clk = 1'b0;
    logic rst_n;

    uart_rx_byte_if ifc ();

    uart_rx_byte #(
        .CLK_FREQ   (CLK_HZ),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (ifc)
    );

    always #10 clk = ~clk;

    int unsigned bit_clk [0:7] = '{768, 384, 192, 128, 64, 768, 768, 768};

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] exp_b, got_b;

    int   done_cnt    = 0;
    int   ferr_cnt    = 0;
    int   overlap_cnt = 0;
    int   long_cnt    = 0;
    logic busy_at_done = 1'b0;
    logic last_done    = 1'b0;
    logic last_ferr    = 1'b0;

    always @(negedge clk) begin
        if (ifc.Rx_done === 1'b1) begin
            done_cnt++;
            got_q.push_back(ifc.data_byte);
            busy_at_done = ifc.rx_busy;
        end
        if (ifc.frame_err === 1'b1) ferr_cnt++;
        if (ifc.Rx_done === 1'b1 && ifc.frame_err === 1'b1) overlap_cnt++;
        if ((ifc.Rx_done === 1'b1 && last_done) || (ifc.frame_err === 1'b1 && last_ferr)) long_cnt++;
        last_done = (ifc.Rx_done === 1'b1);
        last_ferr = (ifc.frame_err === 1'b1);
    end

    task automatic drive_bit(input logic lvl, input int unsigned n);
        ifc.uart_rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned bc, input bit push);
        if (push) exp_q.push_back(b);
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
        drive_bit(1'b1, bc);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ifc.uart_rx  = 1'b1;
        ifc.Buad_set = 3'd0;
        repeat (5) @(negedge clk);
        vectors++;
        if (ifc.data_byte !== 8'h00) begin miscompares++; $display("FAIL reset_data: got 0x%02h want 0x00", ifc.data_byte); end
        vectors++;
        if (ifc.Rx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", ifc.Rx_done); end
        vectors++;
        if (ifc.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", ifc.frame_err); end
        vectors++;
        if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", ifc.rx_busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL release_busy: got %b want 0", ifc.rx_busy); end
    endtask

    task automatic test_basic();
        int d0, f0;
        ifc.Buad_set = 3'd4;
        drive_bit(1'b1, 2 * bit_clk[4]);
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'h55, bit_clk[4], 1'b1);
        vectors++;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        vectors++;
        if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL basic_ferr_count: got %0d want 0", ferr_cnt - f0); end
        vectors++;
        if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        vectors++;
        if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", ifc.rx_busy); end
        vectors++;
        if (ifc.data_byte !== 8'h55) begin miscompares++; $display("FAIL basic_data_hold: got 0x%02h want 0x55", ifc.data_byte); end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL basic_byte: got none want 0x%02h", exp_b);
            end else begin
                got_b = got_q.pop_front();
                if (got_b !== exp_b) begin miscompares++; $display("FAIL basic_byte: got 0x%02h want 0x%02h", got_b, exp_b); end
            end
        end
    endtask

    task automatic test_skew();
        int d0;
        ifc.Buad_set = 3'd0;
        drive_bit(1'b1, bit_clk[0]);
        d0 = done_cnt;
        send_byte(8'hA3, (bit_clk[0] * 102) / 100, 1'b1);
        drive_bit(1'b1, bit_clk[0]);
        send_byte(8'hA3, (bit_clk[0] * 98) / 100, 1'b1);
        vectors++;
        if (done_cnt - d0 !== 2) begin miscompares++; $display("FAIL skew_done_count: got %0d want 2", done_cnt - d0); end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL skew_byte: got none want 0x%02h", exp_b);
            end else begin
                got_b = got_q.pop_front();
                if (got_b !== exp_b) begin miscompares++; $display("FAIL skew_byte: got 0x%02h want 0x%02h", got_b, exp_b); end
            end
        end
    endtask

    task automatic test_false_start();
        int d0, f0;
        int unsigned glitch;
        ifc.Buad_set = 3'd0;
        glitch = (bit_clk[0] * 1500) / 5208;
        drive_bit(1'b1, bit_clk[0]);
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0, glitch);
        drive_bit(1'b1, 20);
        vectors++;
        if (ifc.rx_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_on: got %b want 1", ifc.rx_busy); end
        drive_bit(1'b1, bit_clk[0] - glitch - 20);
        vectors++;
        if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_off: got %b want 0", ifc.rx_busy); end
        vectors++;
        if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0); end
        vectors++;
        if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt - f0); end
        drive_bit(1'b1, bit_clk[0]);
    endtask

    task automatic test_frame_error();
        int d0, f0;
        int unsigned bc;
        ifc.Buad_set = 3'd3;
        bc = bit_clk[3];
        drive_bit(1'b1, bc);
        send_byte(8'h3C, bc, 1'b1);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL ferr_prior_byte: got none want 0x%02h", exp_b);
            end else begin
                got_b = got_q.pop_front();
                if (got_b !== exp_b) begin miscompares++; $display("FAIL ferr_prior_byte: got 0x%02h want 0x%02h", got_b, exp_b); end
            end
        end
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0, bc);
        drive_bit(1'b0, 8 * bc);
        drive_bit(1'b0, 3 * bc);
        vectors++;
        if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        vectors++;
        if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0); end
        vectors++;
        if (ifc.data_byte !== 8'h3C) begin miscompares++; $display("FAIL ferr_data_kept: got 0x%02h want 0x3c", ifc.data_byte); end
        vectors++;
        if (ifc.rx_busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_low_line: got %b want 1", ifc.rx_busy); end
        drive_bit(1'b1, 8);
        vectors++;
        if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_high_line: got %b want 0", ifc.rx_busy); end
        drive_bit(1'b1, bc);
        vectors++;
        if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_single: got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        ifc.Buad_set = 3'd3;
        drive_bit(1'b1, bit_clk[3]);
        d0 = done_cnt;
        send_byte(8'h01, bit_clk[3], 1'b1);
        send_byte(8'h80, bit_clk[3], 1'b1);
        send_byte(8'hFF, bit_clk[3], 1'b1);
        drive_bit(1'b1, bit_clk[3]);
        vectors++;
        if (done_cnt - d0 !== 3) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_byte: got none want 0x%02h", exp_b);
            end else begin
                got_b = got_q.pop_front();
                if (got_b !== exp_b) begin miscompares++; $display("FAIL b2b_byte: got 0x%02h want 0x%02h", got_b, exp_b); end
            end
        end
        vectors++;
        if (got_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra: got %0d extra bytes want 0", got_q.size()); end
        got_q.delete();
    endtask

    // Models a loopback whose transmitter shares the reset: the line goes
    // idle when reset is pulsed, then a fresh 0x7E frame follows.
    task automatic test_reset_midframe();
        logic [7:0] v;
        int unsigned bc;
        int d0, f0;
        v = 8'h7E;
        for (int b = 0; b < 5; b++) begin
            ifc.Buad_set = 3'(b);
            bc = bit_clk[b];
            drive_bit(1'b1, bc);
            d0 = done_cnt; f0 = ferr_cnt;
            drive_bit(1'b0, bc);
            for (int i = 0; i < 4; i++) drive_bit(v[i], bc);
            drive_bit(v[4], bc / 2);
            rst_n = 1'b0;
            ifc.uart_rx = 1'b1;
            repeat (3) @(negedge clk);
            vectors++;
            if (ifc.data_byte !== 8'h00) begin miscompares++; $display("FAIL midrst_data[%0d]: got 0x%02h want 0x00", b, ifc.data_byte); end
            vectors++;
            if (ifc.rx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy[%0d]: got %b want 0", b, ifc.rx_busy); end
            rst_n = 1'b1;
            drive_bit(1'b1, 2 * bc);
            vectors++;
            if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
                miscompares++; $display("FAIL midrst_strobe[%0d]: got done %0d ferr %0d want 0 0", b, done_cnt - d0, ferr_cnt - f0);
            end
            send_byte(8'h7E, bc, 1'b1);
            while (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                vectors++;
                if (got_q.size() == 0) begin
                    miscompares++; $display("FAIL midrst_byte[%0d]: got none want 0x%02h", b, exp_b);
                end else begin
                    got_b = got_q.pop_front();
                    if (got_b !== exp_b) begin miscompares++; $display("FAIL midrst_byte[%0d]: got 0x%02h want 0x%02h", b, got_b, exp_b); end
                end
            end
            vectors++;
            if (got_q.size() != 0) begin miscompares++; $display("FAIL midrst_extra[%0d]: got %0d extra want 0", b, got_q.size()); end
            got_q.delete();
        end
    endtask

    task automatic test_strobe_rules();
        vectors++;
        if (overlap_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
        vectors++;
        if (long_cnt !== 0) begin miscompares++; $display("FAIL strobe_width: got %0d long pulses want 0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_strobe_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
